// File: rtl/io_halfduplex_ctrl_pkg.sv
// Shared types and frame constants for the half-duplex single-wire pad controller.
package io_halfduplex_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_GUARD,
        TX_SHIFT,
        TX_TURN,
        RX_START,
        RX_SHIFT,
        RX_STOP,
        RX_BREAK
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for the pad input; resets to the idle line level.
module io_sync2
    import io_halfduplex_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_halfduplex_ctrl.sv
// Core-side controller for a half-duplex single-wire pad: frames TX words onto the
// tri-state buffer, deframes RX words from it, and owns the bus turnaround.
module io_halfduplex_ctrl
    import io_halfduplex_ctrl_pkg::*;
#(
    parameter int W       = 8,
    parameter int BIT_CYC = 16,
    parameter int GUARD   = 2,
    parameter int TURN    = 2
) (
    input  logic         C,
    input  logic         R,
    input  logic [W-1:0] TX_DATA,
    input  logic         TX_VALID,
    output logic         TX_READY,
    output logic [W-1:0] RX_DATA,
    output logic         RX_VALID,
    output logic         RX_ERR,
    output logic         BUSY,
    input  logic         PAD_I,
    output logic         PAD_O,
    output logic         PAD_T
);

    localparam int CYC_W   = $clog2(BIT_CYC);
    localparam int BIT_W   = $clog2(W + 2);
    localparam int GAP_MAX = (GUARD > TURN) ? GUARD : TURN;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] HALF_LAST  = CYC_W'(BIT_CYC / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(W - 1);
    localparam logic [BIT_W-1:0] DATA_END   = BIT_W'(W);
    localparam logic [BIT_W-1:0] STOP_IDX   = BIT_W'(W + 1);
    localparam logic [GAP_W-1:0] GUARD_LAST = GAP_W'(GUARD - 1);
    localparam logic [GAP_W-1:0] TURN_LAST  = GAP_W'(TURN - 1);

    state_t             state, state_nxt;
    logic [CYC_W-1:0]   cyc_cnt, cyc_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [W-1:0]       tx_shift, tx_shift_nxt;
    logic [W-1:0]       rx_shift, rx_shift_nxt;
    logic [W-1:0]       rx_data_nxt;
    logic               pad_o_nxt, pad_t_nxt;
    logic               rx_valid_nxt, rx_err_nxt;
    logic               s, s_prev;
    logic               rx_start, tx_fire;

    io_sync2 u_sync (
        .clk (C),
        .rst (R),
        .d   (PAD_I),
        .q   (s)
    );

    // A falling edge on the synchronized line while idle claims the bus for RX,
    // which is why it blocks a TX handshake offered in the same cycle.
    assign rx_start = (state == IDLE) && (s_prev == IDLE_LEVEL) && (s == START_BIT);
    assign TX_READY = (state == IDLE) && !rx_start && !R;
    assign tx_fire  = TX_VALID && TX_READY;
    assign BUSY     = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        cyc_nxt      = cyc_cnt;
        bit_nxt      = bit_cnt;
        gap_nxt      = gap_cnt;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        rx_data_nxt  = RX_DATA;
        pad_o_nxt    = PAD_O;
        pad_t_nxt    = PAD_T;
        rx_valid_nxt = 1'b0;
        rx_err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                pad_t_nxt = 1'b1;
                pad_o_nxt = IDLE_LEVEL;
                if (rx_start) begin
                    state_nxt = RX_START;
                    cyc_nxt   = '0;
                end else if (tx_fire) begin
                    state_nxt    = TX_GUARD;
                    gap_nxt      = '0;
                    tx_shift_nxt = TX_DATA;
                    pad_t_nxt    = 1'b0;
                    pad_o_nxt    = IDLE_LEVEL;
                end
            end

            TX_GUARD: begin
                if (gap_cnt == GUARD_LAST) begin
                    state_nxt = TX_SHIFT;
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    pad_o_nxt = START_BIT;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end

            // bit_cnt is the frame bit currently on the pad: 0 start, 1..W data, W+1 stop.
            TX_SHIFT: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nxt = '0;
                    if (bit_cnt == STOP_IDX) begin
                        state_nxt = TX_TURN;
                        gap_nxt   = '0;
                        pad_t_nxt = 1'b1;
                        pad_o_nxt = IDLE_LEVEL;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                        if (bit_cnt < DATA_END) begin
                            pad_o_nxt    = tx_shift[0];
                            tx_shift_nxt = tx_shift >> 1;
                        end else begin
                            pad_o_nxt = STOP_BIT;
                        end
                    end
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end

            TX_TURN: begin
                if (gap_cnt == TURN_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end

            RX_START: begin
                if (cyc_cnt == HALF_LAST) begin
                    cyc_nxt = '0;
                    bit_nxt = '0;
                    state_nxt = (s == START_BIT) ? RX_SHIFT : IDLE;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end

            RX_SHIFT: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nxt              = '0;
                    rx_shift_nxt         = rx_shift >> 1;
                    rx_shift_nxt[W-1]    = s;
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end

            // Leaving at mid-stop-bit lets a following start edge be caught with no dead time.
            RX_STOP: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nxt = '0;
                    if (s == STOP_BIT) begin
                        rx_valid_nxt = 1'b1;
                        rx_data_nxt  = rx_shift;
                        state_nxt    = IDLE;
                    end else begin
                        rx_err_nxt = 1'b1;
                        state_nxt  = RX_BREAK;
                    end
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end

            RX_BREAK: begin
                if (s == IDLE_LEVEL) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                pad_t_nxt = 1'b1;
                pad_o_nxt = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            s_prev   <= IDLE_LEVEL;
            PAD_T    <= 1'b1;
            PAD_O    <= IDLE_LEVEL;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
            RX_ERR   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cyc_cnt  <= cyc_nxt;
            bit_cnt  <= bit_nxt;
            gap_cnt  <= gap_nxt;
            s_prev   <= s;
            PAD_T    <= pad_t_nxt;
            PAD_O    <= pad_o_nxt;
            RX_DATA  <= rx_data_nxt;
            RX_VALID <= rx_valid_nxt;
            RX_ERR   <= rx_err_nxt;
        end
    end

    always_ff @(posedge C) begin
        tx_shift <= tx_shift_nxt;
        rx_shift <= rx_shift_nxt;
    end

endmodule

// File: tb/tb_io_halfduplex_ctrl.sv
// Directed bench for io_halfduplex_ctrl: pad modelled with pull-up, bench driver and contention monitor.
module tb_io_halfduplex_ctrl;

    localparam int W       = 8;
    localparam int BIT_CYC = 4;
    localparam int GUARD   = 2;
    localparam int TURN    = 2;
    localparam int FRAME   = (W + 2) * BIT_CYC;
    localparam int TX_LEN  = GUARD + FRAME + TURN;

    logic         C;
    logic         R;
    logic [W-1:0] TX_DATA;
    logic         TX_VALID;
    logic         TX_READY;
    logic [W-1:0] RX_DATA;
    logic         RX_VALID;
    logic         RX_ERR;
    logic         BUSY;
    logic         PAD_I;
    logic         PAD_O;
    logic         PAD_T;

    logic bench_drv;
    logic bench_val;

    int checks   = 0;
    int failures = 0;

    int rv_seen     = 0;
    int re_seen     = 0;
    int drive_cnt   = 0;
    int busy_cnt    = 0;
    int contention  = 0;
    int both_pulses = 0;

    io_halfduplex_ctrl #(
        .W       (W),
        .BIT_CYC (BIT_CYC),
        .GUARD   (GUARD),
        .TURN    (TURN)
    ) dut (
        .C        (C),
        .R        (R),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_ERR   (RX_ERR),
        .BUSY     (BUSY),
        .PAD_I    (PAD_I),
        .PAD_O    (PAD_O),
        .PAD_T    (PAD_T)
    );

    // Pad: DUT drive wins when enabled, else bench driver, else pull-up.
    assign PAD_I = !PAD_T ? PAD_O : (bench_drv ? bench_val : 1'b1);

    initial C = 1'b0;
    always #5 C = ~C;

    always @(negedge C) begin
        if (RX_VALID) rv_seen++;
        if (RX_ERR) re_seen++;
        if (RX_VALID && RX_ERR) both_pulses++;
        if (!PAD_T) drive_cnt++;
        if (!PAD_T && bench_drv) contention++;
        if (BUSY) busy_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Waits for the handshake with TX_VALID already raised, then drops TX_VALID and scrambles TX_DATA.
    task automatic do_handshake();
        int n;
        n = 0;
        while (!TX_READY && n < 200) begin
            tick();
            n++;
        end
        check_eq("tx_hs_wait", (n < 200), 1);
        tick();
        TX_VALID = 1'b0;
        TX_DATA  = ~TX_DATA;
    endtask

    // Called just after the handshake edge; walks guard, frame, turn and the return to idle.
    task automatic expect_tx(input logic [W-1:0] d);
        logic [W+1:0] frame;
        logic         exp_o;
        logic         exp_t;
        frame = {1'b1, d, 1'b0};
        for (int i = 0; i < TX_LEN; i++) begin
            exp_t = (i >= GUARD + FRAME);
            if (i < GUARD || exp_t) exp_o = 1'b1;
            else exp_o = frame[(i - GUARD) / BIT_CYC];
            check_eq("tx_pad_t", PAD_T, exp_t);
            if (!exp_t) check_eq("tx_pad_o", PAD_O, exp_o);
            check_eq("tx_busy", BUSY, 1);
            check_eq("tx_ready_busy", TX_READY, 0);
            tick();
        end
        check_eq("tx_ready_after", TX_READY, 1);
        check_eq("tx_idle_after", BUSY, 0);
    endtask

    // Drives one frame from the bench side; leaves the line driven at the stop level.
    task automatic rx_frame(input logic [W-1:0] d, input logic stop_val, input int stop_len,
                            input int tx_at);
        int k;
        int len;
        logic v;
        k = 0;
        for (int b = 0; b < W + 2; b++) begin
            if (b == 0) v = 1'b0;
            else if (b <= W) v = d[b-1];
            else v = stop_val;
            len = (b == W + 1) ? stop_len : BIT_CYC;
            for (int j = 0; j < len; j++) begin
                bench_drv = 1'b1;
                bench_val = v;
                if (k == tx_at) begin
                    TX_VALID = 1'b1;
                    check_eq("collide_tx_ready", TX_READY, 0);
                end
                tick();
                k++;
            end
        end
    endtask

    initial begin
        int rv0, re0, dr0, bz0;
        R         = 1'b1;
        TX_DATA   = '0;
        TX_VALID  = 1'b0;
        bench_drv = 1'b0;
        bench_val = 1'b1;

        // Reset
        idle(3);
        check_eq("rst_pad_t", PAD_T, 1);
        check_eq("rst_pad_o", PAD_O, 1);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_rx_valid", RX_VALID, 0);
        check_eq("rst_rx_err", RX_ERR, 0);
        check_eq("rst_rx_data", RX_DATA, 0);
        check_eq("rst_tx_ready_in_rst", TX_READY, 0);
        R = 1'b0;
        #1;
        check_eq("rst_tx_ready", TX_READY, 1);
        idle(2);

        // TX 0xA5
        TX_DATA  = 8'hA5;
        TX_VALID = 1'b1;
        do_handshake();
        expect_tx(8'hA5);
        idle(3);

        // RX 0x3C
        rv0 = rv_seen; re0 = re_seen; dr0 = drive_cnt;
        rx_frame(8'h3C, 1'b1, BIT_CYC, -1);
        bench_drv = 1'b0;
        idle(6);
        check_eq("rx_valid_count", rv_seen - rv0, 1);
        check_eq("rx_err_count", re_seen - re0, 0);
        check_eq("rx_data", RX_DATA, 8'h3C);
        check_eq("rx_no_drive", drive_cnt - dr0, 0);
        check_eq("rx_idle", BUSY, 0);

        // Framing error: 0x55 with stop held low
        rv0 = rv_seen; re0 = re_seen;
        rx_frame(8'h55, 1'b0, 10, -1);
        check_eq("ferr_err_count", re_seen - re0, 1);
        check_eq("ferr_valid_count", rv_seen - rv0, 0);
        check_eq("ferr_busy_low", BUSY, 1);
        bench_drv = 1'b0;
        idle(6);
        check_eq("ferr_idle", BUSY, 0);
        check_eq("ferr_rx_data", RX_DATA, 8'h3C);
        check_eq("ferr_err_once", re_seen - re0, 1);

        // Glitch: one low cycle
        rv0 = rv_seen; re0 = re_seen; bz0 = busy_cnt;
        bench_drv = 1'b1;
        bench_val = 1'b0;
        tick();
        bench_drv = 1'b0;
        idle(8);
        check_eq("glitch_busy_cycles", busy_cnt - bz0, 2);
        check_eq("glitch_idle", BUSY, 0);
        check_eq("glitch_no_valid", rv_seen - rv0, 0);
        check_eq("glitch_no_err", re_seen - re0, 0);

        // Collision: TX_VALID raised on the rx_start cycle
        rv0 = rv_seen;
        TX_DATA = 8'h5A;
        rx_frame(8'h96, 1'b1, BIT_CYC, 2);
        bench_drv = 1'b0;
        do_handshake();
        check_eq("collide_rx_valid", rv_seen - rv0, 1);
        check_eq("collide_rx_data", RX_DATA, 8'h96);
        expect_tx(8'h5A);
        idle(2);

        // Reset during data bit 3 of 0xFF
        TX_DATA  = 8'hFF;
        TX_VALID = 1'b1;
        do_handshake();
        idle(GUARD + 4 * BIT_CYC);
        check_eq("abort_driving", PAD_T, 0);
        R = 1'b1;
        tick();
        check_eq("abort_pad_t", PAD_T, 1);
        check_eq("abort_pad_o", PAD_O, 1);
        check_eq("abort_busy", BUSY, 0);
        check_eq("abort_tx_ready_in_rst", TX_READY, 0);
        R = 1'b0;
        rv0 = rv_seen; re0 = re_seen; dr0 = drive_cnt;
        idle(10);
        check_eq("abort_no_drive", drive_cnt - dr0, 0);
        check_eq("abort_no_valid", rv_seen - rv0, 0);
        check_eq("abort_no_err", re_seen - re0, 0);
        TX_DATA  = 8'h81;
        TX_VALID = 1'b1;
        do_handshake();
        expect_tx(8'h81);
        idle(2);

        check_eq("no_contention", contention, 0);
        check_eq("never_both_pulses", both_pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
